// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the ROM, and queues
// returned instructions with their PCs in a 2-entry buffer toward decode.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic        halt_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    input  logic        id_ready_i
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [31:0] buf_pc_q   [2];
    logic [31:0] buf_pc_d   [2];
    logic [31:0] buf_inst_q [2];
    logic [31:0] buf_inst_d [2];

    logic        pop_s;
    logic        push_s;
    logic [31:0] redirect_tgt_s;

    // Handshake qualification; a redirect suppresses both pop and fetch.
    always_comb begin
        pop_s          = (count_q != 2'd0) && id_ready_i && !redirect_i;
        push_s         = (state_q == ST_RUN) && !halt_i && !redirect_i &&
                         ((count_q < 2'd2) || pop_s);
        redirect_tgt_s = redirect_pc_i & 32'hFFFF_FFFC;
    end

    assign rom_ce_o   = push_s;
    assign rom_addr_o = pc_q;

    // Next-state computation for FSM, PC and fetch buffer.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;

        case (state_q)
            ST_BOOT: state_d = halt_i ? ST_HALT : ST_RUN;
            ST_RUN:  state_d = halt_i ? ST_HALT : ST_RUN;
            ST_HALT: state_d = halt_i ? ST_HALT : ST_RUN;
            default: state_d = ST_BOOT;
        endcase

        if (redirect_i) begin
            // Flush wins over any handshake; the FSM holds its state.
            state_d = state_q;
            pc_d    = redirect_tgt_s;
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (push_s) begin
                buf_pc_d[tail_q]   = pc_q;
                buf_inst_d[tail_q] = rom_inst_i;
                tail_d             = ~tail_q;
                pc_d               = pc_q + 32'd4;
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = ~head_q;
            end else begin
                head_d = head_q;
            end
            count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            buf_pc_q[0]   <= 32'h0000_0000;
            buf_pc_q[1]   <= 32'h0000_0000;
            buf_inst_q[0] <= 32'h0000_0000;
            buf_inst_q[1] <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            buf_pc_q[0]   <= buf_pc_d[0];
            buf_pc_q[1]   <= buf_pc_d[1];
            buf_inst_q[0] <= buf_inst_d[0];
            buf_inst_q[1] <= buf_inst_d[1];
        end
    end

    // Head entry is shown straight from the buffer, zeroed when empty.
    always_comb begin
        if (count_q != 2'd0) begin
            if_valid_o = 1'b1;
            if_pc_o    = buf_pc_q[head_q];
            if_inst_o  = buf_inst_q[head_q];
        end else begin
            if_valid_o = 1'b0;
            if_pc_o    = 32'h0000_0000;
            if_inst_o  = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl against a ROM returning 0x1000_0000 + word index.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;

    int n_tests;
    int n_fail;

    inst_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_ce_o      (rom_ce),
        .rom_addr_o    (rom_addr),
        .rom_inst_i    (rom_inst),
        .halt_i        (halt),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .if_valid_o    (if_valid),
        .if_pc_o       (if_pc),
        .if_inst_o     (if_inst),
        .id_ready_i    (id_ready)
    );

    assign rom_inst = 32'h1000_0000 + {2'b00, rom_addr[31:2]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        halt = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #4;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
        #3;
        n_tests++; if (rom_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce got %b want 0", rom_ce); end
        n_tests++; if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", rom_addr); end
        n_tests++; if ({if_valid, if_pc, if_inst} !== 65'h0) begin n_fail++; $display("FAIL reset_if got %b %h %h want 0", if_valid, if_pc, if_inst); end
        @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        n_tests++; if (rom_ce !== 1'b0) begin n_fail++; $display("FAIL boot_ce got %b want 0", rom_ce); end
        tick;
        n_tests++; if (rom_ce !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL first_fetch got ce=%b v=%b want ce=1 v=0", rom_ce, if_valid); end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_tests++;
            if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_inst !== 32'h1000_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL boot_seq%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, if_valid, if_pc, if_inst, 32'(i * 4), 32'h1000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_backpressure;
        id_ready = 1'b0;
        do_reset;
        tick;
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_fail++; $display("FAIL bp_first got v=%b pc=%h want v=1 pc=0", if_valid, if_pc); end
        for (int i = 0; i < 5; i++) begin
            tick;
            n_tests++;
            if (if_pc !== 32'h0 || rom_ce !== 1'b0 || if_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d got pc=%h ce=%b v=%b want pc=0 ce=0 v=1", i, if_pc, rom_ce, if_valid);
            end
        end
        id_ready = 1'b1;
        #1;
        n_tests++; if (rom_ce !== 1'b1 || rom_addr !== 32'h8) begin n_fail++; $display("FAIL bp_full_pop_push got ce=%b addr=%h want ce=1 addr=8", rom_ce, rom_addr); end
        n_tests++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL bp_rel0 got %h want 0", if_pc); end
        for (int i = 1; i < 4; i++) begin
            tick;
            n_tests++;
            if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_inst !== 32'h1000_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL bp_rel%0d got pc=%h inst=%h want pc=%h inst=%h",
                         i, if_pc, if_inst, 32'(i * 4), 32'h1000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_redirect;
        id_ready = 1'b0;
        tick;
        tick;
        n_tests++; if (rom_ce !== 1'b0 || if_valid !== 1'b1) begin n_fail++; $display("FAIL rd_full got ce=%b v=%b want ce=0 v=1", rom_ce, if_valid); end
        redirect = 1'b1;
        redirect_pc = 32'h0000_0043;
        id_ready = 1'b1;
        #1;
        n_tests++; if (rom_ce !== 1'b0) begin n_fail++; $display("FAIL rd_ce got %b want 0", rom_ce); end
        tick;
        redirect = 1'b0;
        #1;
        n_tests++; if (if_valid !== 1'b0 || if_pc !== 32'h0) begin n_fail++; $display("FAIL rd_flush got v=%b pc=%h want v=0 pc=0", if_valid, if_pc); end
        n_tests++; if (rom_ce !== 1'b1 || rom_addr !== 32'h40) begin n_fail++; $display("FAIL rd_target got ce=%b addr=%h want ce=1 addr=40", rom_ce, rom_addr); end
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_inst !== 32'h1000_0010) begin n_fail++; $display("FAIL rd_40 got pc=%h inst=%h want 40 10000010", if_pc, if_inst); end
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h44 || if_inst !== 32'h1000_0011) begin n_fail++; $display("FAIL rd_44 got pc=%h inst=%h want 44 10000011", if_pc, if_inst); end
    endtask

    task automatic test_halt;
        id_ready = 1'b0;
        tick;
        n_tests++; if (if_pc !== 32'h44) begin n_fail++; $display("FAIL halt_pre got %h want 44", if_pc); end
        halt = 1'b1;
        id_ready = 1'b1;
        #1;
        n_tests++; if (rom_ce !== 1'b0) begin n_fail++; $display("FAIL halt_ce got %b want 0", rom_ce); end
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h48 || if_inst !== 32'h1000_0012) begin n_fail++; $display("FAIL halt_drain got v=%b pc=%h inst=%h want 1 48 10000012", if_valid, if_pc, if_inst); end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_tests++;
            if (if_valid !== 1'b0 || rom_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_idle%0d got v=%b ce=%b want 0 0", i, if_valid, rom_ce);
            end
        end
        halt = 1'b0;
        #1;
        n_tests++; if (rom_ce !== 1'b0) begin n_fail++; $display("FAIL halt_exit_ce got %b want 0", rom_ce); end
        tick;
        n_tests++; if (rom_ce !== 1'b1 || rom_addr !== 32'h4C) begin n_fail++; $display("FAIL halt_resume got ce=%b addr=%h want 1 4c", rom_ce, rom_addr); end
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h4C) begin n_fail++; $display("FAIL halt_resume_data got v=%b pc=%h want 1 4c", if_valid, if_pc); end
    endtask

    task automatic test_halt_redirect_wrap;
        halt = 1'b1;
        tick;
        tick;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        #1;
        n_tests++; if (rom_ce !== 1'b0) begin n_fail++; $display("FAIL hw_ce got %b want 0", rom_ce); end
        tick;
        redirect = 1'b0;
        halt = 1'b0;
        #1;
        n_tests++; if (rom_ce !== 1'b0 || rom_addr !== 32'hFFFF_FFF8 || if_valid !== 1'b0) begin n_fail++; $display("FAIL hw_pc got ce=%b addr=%h v=%b want 0 fffffff8 0", rom_ce, rom_addr, if_valid); end
        tick;
        n_tests++; if (rom_ce !== 1'b1) begin n_fail++; $display("FAIL hw_resume got %b want 1", rom_ce); end
        tick;
        n_tests++; if (if_pc !== 32'hFFFF_FFF8 || if_inst !== 32'h4FFF_FFFE) begin n_fail++; $display("FAIL hw_fff8 got pc=%h inst=%h want fffffff8 4ffffffe", if_pc, if_inst); end
        tick;
        n_tests++; if (if_pc !== 32'hFFFF_FFFC || if_inst !== 32'h4FFF_FFFF) begin n_fail++; $display("FAIL hw_fffc got pc=%h inst=%h want fffffffc 4fffffff", if_pc, if_inst); end
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h1000_0000) begin n_fail++; $display("FAIL hw_wrap got v=%b pc=%h inst=%h want 1 0 10000000", if_valid, if_pc, if_inst); end
    endtask

    task automatic test_async_reset;
        tick;
        n_tests++; if (if_pc !== 32'h4) begin n_fail++; $display("FAIL ar_pre got %h want 4", if_pc); end
        #1;
        rst = 1'b0;
        #1;
        n_tests++; if ({rom_ce, rom_addr, if_valid, if_pc, if_inst} !== 98'h0) begin n_fail++; $display("FAIL ar_now got ce=%b addr=%h v=%b pc=%h inst=%h want all 0", rom_ce, rom_addr, if_valid, if_pc, if_inst); end
        tick;
        n_tests++; if (if_valid !== 1'b0 || rom_ce !== 1'b0) begin n_fail++; $display("FAIL ar_hold got v=%b ce=%b want 0 0", if_valid, rom_ce); end
        @(posedge clk);
        #4;
        rst = 1'b1;
        tick;
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL ar_boot got %b want 0", if_valid); end
        tick;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h1000_0000) begin n_fail++; $display("FAIL ar_first got v=%b pc=%h inst=%h want 1 0 10000000", if_valid, if_pc, if_inst); end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        id_ready = 1'b1;
        test_reset;
        test_backpressure;
        test_redirect;
        test_halt;
        test_halt_redirect_wrap;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction fetch controller that sequences the instruction ROM. It owns the PC and drives the ROM chip-enable and address. Each returned instruction is captured with its PC into a 2-entry fetch buffer, which is presented to the decode stage over a valid/ready handshake. Branch/jump redirects flush the buffer, and a halt input suspends fetching. The block sits between the ROM and the IF/ID boundary and replaces a free-running PC register.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rom_ce_o  out  1  ROM chip enable; 1 = ChipEnable, 0 = ChipDisable.
- rom_addr_o  out  32  byte address to ROM; always the current PC.
- rom_inst_i  in  32  ROM read data; combinational response to rom_ce_o/rom_addr_o in the same cycle.
- halt_i  in  1  level; 1 = issue no new fetches.
- redirect_i  in  1  one-cycle pulse; a taken branch/jump.
- redirect_pc_i  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- if_valid_o  out  1  buffer head holds a valid instruction.
- if_pc_o  out  32  PC of the head entry; 0 when empty.
- if_inst_o  out  32  instruction of the head entry; ZeroWord when empty.
- id_ready_i  in  1  decode accepts the head entry this cycle.

## Operation
- **State machine** (BOOT, RUN, HALT):
  - BOOT is entered on reset and lasts exactly one cycle after rst deasserts. It is followed by RUN, or by HALT if halt_i=1.
  - RUN -> HALT when halt_i=1. HALT -> RUN when halt_i=0.
- **Pop:** occurs when if_valid_o=1 and id_ready_i=1.
- **Push (fetch):** rom_ce_o = 1 when all of the following hold:
  - state is RUN;
  - halt_i=0 and redirect_i=0;
  - count<2, or count==2 with a pop in the same cycle.
- **On a push at the clock edge:**
  - {pc, rom_inst_i} is written to the buffer tail;
  - pc <= pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000;
  - count is updated by push minus pop.
- **Redirect priority** (redirect_i=1): overrides push and pop in any state.
  - buffer cleared (count <= 0);
  - pc <= {redirect_pc_i[31:2], 2'b00};
  - rom_ce_o = 0 that cycle;
  - state is unchanged. A redirect while in HALT updates pc only.
- **Halt:** only new fetches stop. Buffered entries still drain through pops.
- **Buffer:** 2-entry FIFO with head/tail pointers and a 2-bit count. The head is presented directly on the if_* outputs. When count = 0, outputs are forced to 0.
- **Simultaneous push and pop at count==2:** the head advances, the new entry fills the freed slot, and count stays at 2.
- **Simultaneous push and pop at count==1:** output moves to the new entry next cycle, count stays at 1.
- **Empty buffer:** id_ready_i has no effect.

## Timing
- **Reset values** (asynchronous, while rst=0):
  - pc = RESET_PC, count = 0, state = BOOT;
  - rom_ce_o = 0, rom_addr_o = RESET_PC;
  - if_valid_o = 0, if_pc_o = 0, if_inst_o = 0.
- **Reset mid-operation:** all state returns to the values above immediately. No partial entry survives.
- **Fetch latency:** an instruction read in cycle N appears on if_* in cycle N+1.
- **Throughput:** sustained 1 instruction/cycle when id_ready_i is held high.
- **First fetch:** issued in the cycle after BOOT, i.e. the 2nd rising edge after rst deasserts. First if_valid_o occurs one cycle later.
- **After redirect at edge E:** the fetch from the target is issued in cycle E+1, and its data is valid at E+2.
- **Outputs:** rom_ce_o and rom_addr_o are combinational from state/pc/count/handshake inputs. if_* are derived from registered buffer state only.

## Test plan
- **Reset/boot:** RESET_PC=0x0, ROM[i] = 0x1000_0000+i, id_ready_i=1.
  - Required: rom_ce_o=0 during BOOT.
  - Then if_pc_o/if_inst_o = 0x0/0x1000_0000, 0x4/0x1000_0001, 0x8/0x1000_0002 on consecutive cycles with if_valid_o=1.
- **Backpressure:** hold id_ready_i=0 for 5 cycles.
  - Required: count saturates at 2 and rom_ce_o=0 while full.
  - if_pc_o is held at 0x0.
  - On release, the sequence continues 0x0, 0x4, 0x8 with no gap or duplicate.
- **Redirect:** with the buffer full, pulse redirect_i with redirect_pc_i = 0x0000_0043.
  - Required: if_valid_o=0 next cycle.
  - Then if_pc_o = 0x40, 0x44 with matching ROM data. Flushed entries are never output.
- **Halt:** assert halt_i for 4 cycles with id_ready_i=1.
  - Required: at most 2 buffered entries drain, then if_valid_o=0 and rom_ce_o=0.
  - After deassertion, fetching resumes at the next sequential PC.
- **Redirect during halt, and wrap:** while halted, redirect to 0xFFFF_FFF8, then deassert halt.
  - Required: PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Async reset mid-stream:** drop rst between clock edges.
  - Required: outputs go to reset values immediately.
  - After release, the first valid is pc=RESET_PC.
